// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into words: the first byte of a word lands in
// bits 7:0. word_ready_o pulses for one cycle after the final byte of a word is taken.
module byte_packer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             last_byte_o,
    output logic             word_ready_o,
    output logic [WIDTH-1:0] word_o
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ready_q, ready_d;

    // Next-state: shift bytes in from the top so the oldest byte ends up lowest.
    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        ready_d = 1'b0;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            word_d  = {byte_data_i, word_q[WIDTH-1:8]};
            cnt_d   = cnt_q + 2'd1;
            ready_d = (cnt_q == 2'd3);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 2'd0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign last_byte_o  = (cnt_q == 2'd3);
    assign word_ready_o = ready_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a framed byte stream, writes words to
// sequential imem addresses and releases the core from reset once a frame is complete.
// Optional build macro CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              core_reset_n,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;     // words written so far in this frame
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept, is_sync;
    logic              pk_clear, pk_valid, pk_last, pk_ready;
    logic [WIDTH-1:0]  pk_word;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign accept  = in_valid && in_ready;
    assign is_sync = (in_data == SYNC_BYTE);

    byte_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .byte_valid_i(pk_valid),
        .byte_data_i (in_data),
        .last_byte_o (pk_last),
        .word_ready_o(pk_ready),
        .word_o      (pk_word)
    );

    // Frame-parsing FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        addr_d   = addr_q;
        pk_clear = 1'b0;
        pk_valid = 1'b0;
`ifdef CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (accept && is_sync) begin
                    state_d  = StLen;
                    cnt_d    = '0;
                    addr_d   = '0;
                    pk_clear = 1'b1;
`ifdef CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                end
            end
            StLen: begin
                if (accept) begin
                    if (in_data == 8'h00 || {24'd0, in_data} > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        len_d   = in_data[LEN_W-1:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    pk_valid = 1'b1;
`ifdef CHECKSUM_EN
                    csum_d   = csum_q ^ in_data;
`endif
                    if (pk_last) begin
                        addr_d  = cnt_q[ADDR_W-1:0];
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                cnt_d = cnt_q + LEN_W'(1);
                if ((cnt_q + LEN_W'(1)) == len_q) begin
`ifdef CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
`ifdef CHECKSUM_EN
                if (accept) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
`else
                state_d = StErr;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and frame bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // One bubble per word: no byte is taken while the word is being written.
    assign in_ready     = (state_q != StWrite);
    assign imem_we      = pk_ready;
    assign imem_addr    = addr_q;
    assign imem_wdata   = pk_word;
    assign core_reset_n = (state_q == StDone);
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default and CHECKSUM_EN builds).
module tb_imem_loader;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_wdata;
    logic              core_reset_n;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr [16];
    logic [31:0]       wr_data [16];
    int                nwr = 0;
    logic              bubble_bad = 1'b0;
    int                base;

    imem_loader #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_reset_n(core_reset_n),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Log every imem write; in_ready must be low exactly when imem_we is high.
    always @(negedge clk) begin
        if (in_ready !== !imem_we) bubble_bad = 1'b1;
        if (imem_we === 1'b1 && nwr < 16) begin
            wr_addr[nwr] = imem_addr;
            wr_data[nwr] = imem_wdata;
            nwr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Two-word frame; data XOR is 78^56^34^12^EF^BE^AD^DE = 0x2A.
    task automatic send_frame(input logic [7:0] csum);
        send(8'hA5); send(8'h02);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef CHECKSUM_EN
        send(csum);
`else
        if (csum != 8'h2A) send(csum);
`endif
        idle(4);
    endtask

    task automatic check_words(input string tag, input int b);
        check({tag, "_nwr"}, nwr - b, 2);
        check({tag, "_a0"}, {26'd0, wr_addr[b]}, 32'd0);
        check({tag, "_d0"}, wr_data[b], 32'h1234_5678);
        check({tag, "_a1"}, {26'd0, wr_addr[b+1]}, 32'd1);
        check({tag, "_d1"}, wr_data[b+1], 32'hDEAD_BEEF);
    endtask

    task automatic check_loaded(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_core"}, {31'd0, core_reset_n}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core"}, {31'd0, core_reset_n}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // 1: reset values
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", {31'd0, in_ready}, 32'd1);
        check("rst_rel_core", {31'd0, core_reset_n}, 32'd0);

        // 2: basic two-word frame
        base = nwr;
        send_frame(8'h2A);
        check_words("frm", base);
        check_loaded("frm");
        check("frm_addr_hold", {26'd0, imem_addr}, 32'd1);

        // 3: illegal lengths, then recovery
        base = nwr;
        send(8'hA5); send(8'h00); idle(3);
        check("len0_error", {31'd0, error}, 32'd1);
        check("len0_done", {31'd0, done}, 32'd0);
        check("len0_core", {31'd0, core_reset_n}, 32'd0);
        send(8'hA5); send(8'h41); idle(3);
        check("len65_error", {31'd0, error}, 32'd1);
        check("len65_core", {31'd0, core_reset_n}, 32'd0);
        check("len_nowrite", nwr - base, 0);
        base = nwr;
        send_frame(8'h2A);
        check_words("rec", base);
        check_loaded("rec");

        // 4: garbage while done, then a frame with in_valid gaps
        send(8'h00); send(8'hFF); send(8'h13); idle(2);
        check("garb_done", {31'd0, done}, 32'd1);
        base = nwr;
        send(8'hA5); send(8'h02); idle(1);
        check("resync_core", {31'd0, core_reset_n}, 32'd0);
        check("resync_done", {31'd0, done}, 32'd0);
        send(8'h78); send(8'h56); idle(3);
        send(8'h34); send(8'h12); send(8'hEF); idle(2);
        send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef CHECKSUM_EN
        idle(1);
        send(8'h2A);
`endif
        idle(4);
        check_words("gap", base);
        check_loaded("gap");

`ifdef CHECKSUM_EN
        // 5: bad checksum
        base = nwr;
        send_frame(8'h01);
        check("csum_nwr", nwr - base, 2);
        check("csum_error", {31'd0, error}, 32'd1);
        check("csum_done", {31'd0, done}, 32'd0);
        check("csum_core", {31'd0, core_reset_n}, 32'd0);
`endif

        // 6: async reset mid-frame, then reload
        send(8'hA5); send(8'h02); send(8'h78); send(8'h56);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = nwr;
        send_frame(8'h2A);
        check_words("post", base);
        check_loaded("post");

        check("bubble_only_on_we", {31'd0, bubble_bad}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
